// File: rtl/exec_lane_sequencer_if.sv
// Operation handshake bundle for exec_lane_sequencer.
//   in_valid / in_ready : upstream offers an operation (exc, op_a, op_b, imm)
//   out_valid / out_ready : downstream takes the assembled vector result
// master = upstream/downstream environment, slave = the sequencer.
interface exec_lane_sequencer_if #(
  parameter int LANES  = 8,
  parameter int LANE_W = 24
);
  logic                      in_valid;
  logic                      in_ready;
  logic [4:0]                exc;
  logic [LANES*LANE_W-1:0]   op_a;
  logic [LANES*LANE_W-1:0]   op_b;
  logic [20:0]               imm;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*LANE_W-1:0]   result;

  modport master (
    output in_valid, exc, op_a, op_b, imm, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, exc, op_a, op_b, imm, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/exec_lane_sequencer.sv
// Serialises one vector operation across a single shared lane ALU, one lane
// per cycle, and assembles the per-lane results into a vector.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : abort the in-flight operation, back to IDLE
//   bus       : operation in / result out handshakes (slave side)
//   lane_a/b  : operands presented to the external lane ALU (0 outside RUN)
//   lane_op   : ALU operation code (0 outside RUN)
//   lane_res  : combinational ALU result for the current lane
//   busy      : state is not IDLE
module exec_lane_sequencer #(
  parameter int LANES  = 8,
  parameter int LANE_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  exec_lane_sequencer_if.slave bus,
  output logic [LANE_W-1:0]    lane_a,
  output logic [LANE_W-1:0]    lane_b,
  output logic [2:0]           lane_op,
  input  logic [LANE_W-1:0]    lane_res,
  output logic                 busy
);
  localparam int VEC_W = LANES * LANE_W;
  localparam int IMM_W = 21;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   lane_idx_q, lane_idx_d;
  logic [VEC_W-1:0]   a_q, b_q, result_q;
  logic [IMM_W-1:0]   imm_q;
  logic [2:0]         op_q;
  logic               imm_sel_q;
  logic               accept;
  logic               last_lane;

  assign accept    = (state_q == IDLE) && bus.in_valid && !flush;
  assign last_lane = (lane_idx_q == IDX_W'(LANES - 1));

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      op_q       <= '0;
      imm_sel_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      if (accept) begin
        a_q       <= bus.op_a;
        b_q       <= bus.op_b;
        imm_q     <= bus.imm;
        op_q      <= bus.exc[4] ? 3'b111 : bus.exc[3:1];
        imm_sel_q <= bus.exc[0];
      end
      // A flush on a RUN edge drops that lane; earlier lanes stay written.
      if (state_q == RUN && !flush)
        result_q[lane_idx_q*LANE_W +: LANE_W] <= lane_res;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    if (flush) begin
      state_d    = IDLE;
      lane_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          state_d    = RUN;
          lane_idx_d = '0;
        end
        RUN: begin
          if (last_lane) begin
            state_d    = DONE;
            lane_idx_d = '0;
          end else begin
            lane_idx_d = lane_idx_q + 1'b1;
          end
        end
        DONE: if (bus.out_ready) state_d = IDLE;
        default: begin
          state_d    = IDLE;
          lane_idx_d = '0;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    lane_a        = '0;
    lane_b        = '0;
    lane_op       = '0;
    bus.in_ready  = (state_q == IDLE) && !flush;
    bus.out_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
    if (state_q == RUN) begin
      lane_a  = a_q[lane_idx_q*LANE_W +: LANE_W];
      lane_b  = imm_sel_q ? {{(LANE_W-IMM_W){1'b0}}, imm_q}
                          : b_q[lane_idx_q*LANE_W +: LANE_W];
      lane_op = op_q;
    end
  end

  assign bus.result = result_q;
endmodule
